// File: rtl/conv_mac_feeder.sv
// rtl/conv_mac_feeder.sv - pixel*weight product feeder for the conv accumulator
// Drives clear/enable/data/bias to the accumulator for one window of terms per start.
module conv_mac_feeder #(
  parameter int DATA_W    = 8,
  parameter int MAX_TERMS = 25,
  parameter int CNT_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_terms,
  input  logic [DATA_W-1:0]     cfg_bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_pixel,
  input  logic [DATA_W-1:0]     in_weight,
  output logic                  acc_clr,
  output logic                  acc_ena,
  output logic [2*DATA_W-1:0]   acc_data,
  output logic [DATA_W-1:0]     acc_bias,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FEED  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [CNT_W-1:0]           r_terms;
  logic [CNT_W-1:0]           r_count;
  logic [DATA_W-1:0]          r_bias;
  logic [2*DATA_W-1:0]        r_prod;
  logic                       r_ena;
  logic                       r_done;

  logic                       w_accept;
  logic                       w_last;
  logic                       w_launch;
  logic [CNT_W-1:0]           w_terms_clamped;
  logic signed [2*DATA_W-1:0] w_prod;

  assign w_accept        = in_valid & in_ready;
  assign w_last          = w_accept && (r_count == r_terms - CNT_W'(1));
  assign w_launch        = (r_state == S_IDLE) && start;
  assign w_terms_clamped = (cfg_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : cfg_terms;
  assign w_prod          = $signed(in_pixel) * $signed(in_weight);

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    acc_clr  = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        w_next  = (r_terms == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Product and enable are registered so acc_data/acc_ena trail each accept by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_terms <= '0;
      r_count <= '0;
      r_bias  <= '0;
      r_prod  <= '0;
      r_ena   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ena   <= w_accept;
      r_done  <= (r_state == S_DONE);
      if (w_accept) begin
        r_prod  <= w_prod;
        r_count <= r_count + CNT_W'(1);
      end
      if (w_launch) begin
        r_terms <= w_terms_clamped;
        r_bias  <= cfg_bias;
        r_count <= '0;
      end
    end
  end

  assign acc_ena  = r_ena;
  assign acc_data = r_prod;
  assign acc_bias = r_bias;
  assign done     = r_done;

endmodule

// File: tb/tb_conv_mac_feeder.sv
// tb/tb_conv_mac_feeder.sv - self-checking bench for conv_mac_feeder
// Reference model tracks window progress by term counts; directed tests pin it with literals.
module tb_conv_mac_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_terms = '0;
  logic [7:0]  cfg_bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic [7:0]  in_weight = '0;
  logic        acc_clr;
  logic        acc_ena;
  logic [15:0] acc_data;
  logic [7:0]  acc_bias;
  logic        busy;
  logic        done;

  conv_mac_feeder #(.DATA_W(8), .MAX_TERMS(25), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_terms(cfg_terms), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_weight(in_weight),
    .acc_clr(acc_clr), .acc_ena(acc_ena), .acc_data(acc_data), .acc_bias(acc_bias),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: a window is remembered as "terms still to take" plus clear/tail flags.
  bit          m_busy = 0, m_clr = 0, m_tail = 0, m_ena = 0, m_done = 0;
  int          m_left = 0;
  logic [15:0] m_data = '0;
  logic [7:0]  m_bias = '0;

  always @(posedge clk) begin
    bit take;
    int t;
    if (rst) begin
      m_busy <= 0; m_clr <= 0; m_tail <= 0; m_ena <= 0; m_done <= 0;
      m_left <= 0; m_data <= '0; m_bias <= '0;
    end else begin
      take = m_busy && !m_clr && !m_tail && (m_left > 0) && in_valid;
      m_done <= m_tail;
      m_ena  <= take;
      if (take) m_data <= 16'(int'($signed(in_pixel)) * int'($signed(in_weight)));
      if (!m_busy) begin
        if (start) begin
          t = (int'(cfg_terms) > 25) ? 25 : int'(cfg_terms);
          m_busy <= 1; m_clr <= 1; m_left <= t; m_bias <= cfg_bias;
        end
      end else if (m_clr) begin
        m_clr <= 0;
        if (m_left == 0) m_tail <= 1;
      end else if (m_tail) begin
        m_busy <= 0; m_tail <= 0;
      end else if (take) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_tail <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_busy && !m_clr && !m_tail);
    chk("acc_clr",  acc_clr,  m_clr);
    chk("acc_ena",  acc_ena,  m_ena);
    chk("acc_data", acc_data, m_data);
    chk("acc_bias", acc_bias, m_bias);
    chk("busy",     busy,     m_busy);
    chk("done",     done,     m_done);
  end

  // Pair source: presents the queue head, optionally only on even cycles.
  int q_px[$];
  int q_wt[$];
  bit alt_mode = 0;
  int cyc = 0;

  logic        tr_clr  [0:63];
  logic        tr_ena  [0:63];
  logic [15:0] tr_data [0:63];
  logic        tr_done [0:63];

  task automatic tick();
    bit taken;
    taken = in_valid && in_ready && !rst;
    @(posedge clk);
    #1;
    if (taken) begin
      void'(q_px.pop_front());
      void'(q_wt.pop_front());
    end
    cyc++;
    in_valid = (q_px.size() > 0) && (!alt_mode || (cyc % 2 == 0));
    if (q_px.size() > 0) begin
      in_pixel  = 8'(q_px[0]);
      in_weight = 8'(q_wt[0]);
    end
  endtask

  task automatic push(input int px, input int wt);
    q_px.push_back(px);
    q_wt.push_back(wt);
  endtask

  task automatic flush_q();
    q_px.delete();
    q_wt.delete();
    in_valid = 1'b0;
  endtask

  task automatic trace(input int n, input bit hold_start);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (!hold_start) start = 1'b0;
      tr_clr[k]  = acc_clr;
      tr_ena[k]  = acc_ena;
      tr_data[k] = acc_data;
      tr_done[k] = done;
    end
  endtask

  task automatic launch(input int terms, input int bias);
    cfg_terms = 5'(terms);
    cfg_bias  = 8'(bias);
    start     = 1'b1;
  endtask

  function automatic int count_ena(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (tr_ena[k]) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (tr_done[k]) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    tick(); tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", acc_data, 16'h0000);
    chk("reset_bias", acc_bias, 8'h00);
    rst = 1'b0;
    tick();

    // 1: three-term window, pairs queued before start must wait for FEED
    push(1, 3); push(2, 2); push(3, -1);
    tick(); tick();
    chk("t1_not_consumed_idle", q_px.size(), 3);
    launch(3, 2);
    trace(7, 0);
    chk("t1_clr_c1",  tr_clr[1], 1'b1);
    chk("t1_ena_c2",  tr_ena[2], 1'b0);
    chk("t1_ena_c3",  tr_ena[3], 1'b1);
    chk("t1_data_c3", tr_data[3], 16'h0003);
    chk("t1_data_c4", tr_data[4], 16'h0004);
    chk("t1_data_c5", tr_data[5], 16'hFFFD);
    chk("t1_ena_c5",  tr_ena[5], 1'b1);
    chk("t1_ena_c6",  tr_ena[6], 1'b0);
    chk("t1_done_c6", tr_done[6], 1'b1);
    chk("t1_done_c5", tr_done[5], 1'b0);
    chk("t1_bias",    acc_bias, 8'h02);

    // 2: extreme signed products
    push(-128, -128); push(-128, 127);
    launch(2, -5);
    trace(6, 0);
    chk("t2_min_sq",  tr_data[3], 16'h4000);
    chk("t2_min_max", tr_data[4], 16'hC080);
    chk("t2_done_c5", tr_done[5], 1'b1);

    // 3: stalled input on alternate cycles
    alt_mode = 1;
    push(4, 5); push(-6, 7); push(8, -9); push(10, 11);
    launch(4, 1);
    trace(16, 0);
    chk("t3_ena_count",  count_ena(16), 4);
    chk("t3_done_count", count_done(16), 1);
    alt_mode = 0;

    // 4: empty window, then an over-long window clamped to 25
    launch(0, 7);
    trace(4, 0);
    chk("t4_clr_c1",   tr_clr[1], 1'b1);
    chk("t4_done_c3",  tr_done[3], 1'b1);
    chk("t4_no_ena",   count_ena(4), 0);
    for (int i = 1; i <= 30; i++) push(i, 1);
    launch(31, 3);
    trace(30, 0);
    chk("t4_clamp_ena",  count_ena(30), 25);
    chk("t4_clamp_left", q_px.size(), 5);
    chk("t4_clamp_done", tr_done[28], 1'b1);
    chk("t4_last_data",  tr_data[27], 16'd25);
    flush_q();
    tick();

    // 5: reset landing on the second accept
    for (int i = 1; i <= 5; i++) push(i, 2);
    launch(5, 9);
    tick(); start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    chk("t5_clr",   acc_clr, 1'b0);
    chk("t5_ena",   acc_ena, 1'b0);
    chk("t5_ready", in_ready, 1'b0);
    chk("t5_busy",  busy, 1'b0);
    chk("t5_data",  acc_data, 16'h0000);
    chk("t5_bias",  acc_bias, 8'h00);
    flush_q();
    trace(6, 0);
    chk("t5_quiet_ena",  count_ena(6), 0);
    chk("t5_quiet_done", count_done(6), 0);
    push(5, 6); push(-7, 3);
    launch(2, 1);
    trace(6, 0);
    chk("t5_fresh_d3",   tr_data[3], 16'h001E);
    chk("t5_fresh_d4",   tr_data[4], 16'hFFEB);
    chk("t5_fresh_done", tr_done[5], 1'b1);

    // 6: start held high, back-to-back two-term windows
    for (int i = 1; i <= 8; i++) push(i, -i);
    launch(2, 4);
    for (int k = 1; k <= 16; k++) begin
      tick();
      tr_ena[k]  = acc_ena;
      tr_done[k] = done;
      if (k == 4) chk("t6_bias_kept", acc_bias, 8'h04);
      if (k == 2) begin cfg_bias = 8'd9; cfg_terms = 5'd7; end
      if (k == 4) begin cfg_bias = 8'd4; cfg_terms = 5'd2; end
    end
    start = 1'b0;
    chk("t6_done_c5",  tr_done[5], 1'b1);
    chk("t6_done_c10", tr_done[10], 1'b1);
    chk("t6_done_c15", tr_done[15], 1'b1);
    chk("t6_done_cnt", count_done(16), 3);
    chk("t6_ena_cnt",  count_ena(16), 6);
    trace(8, 0);
    chk("t6_drained", q_px.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
